// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_sb integer register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NREAD_DEF = 2;

    localparam int unsigned ZERO_REG = 32'd0;

    typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, same-cycle issue wins.
// With REGFILE_BYPASS_EN a port reading the register being written sees it as free.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int   NREGS = NREGS_DEF,
    parameter int   NREAD = NREAD_DEF,
    localparam int  AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD-1:0]      rbusy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW-1:0]    w_rd_addr;

    // Next busy state; register 0 can never be set.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            w_busy_nxt[i] = (issue_en && (issue_addr == AW'(i)) && (i != int'(ZERO_REG))) ? 1'b1 :
                            ((we && (wa == AW'(i))) ? 1'b0 : r_busy[i]);
        end
    end

    // Busy bit storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Per-port busy lookup.
    always_comb begin
        rbusy     = '0;
        w_rd_addr = '0;
        for (int p = 0; p < NREAD; p++) begin
            w_rd_addr = ra[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            rbusy[p] = (we && (wa == w_rd_addr) && (wa != '0)) ?
                       (issue_en && (issue_addr == w_rd_addr)) : r_busy[w_rd_addr];
`else
            rbusy[p] = r_busy[w_rd_addr];
`endif
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with zero register, NREAD read ports, busy scoreboard
// and registered debug read channel. Optional write-through forwarding: REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int   XLEN  = XLEN_DEF,
    parameter int   NREGS = NREGS_DEF,
    parameter int   NREAD = NREAD_DEF,
    localparam int  AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    input  logic                  dbg_req,
    input  logic [AW-1:0]         dbg_addr,
    output logic                  dbg_valid,
    output logic [XLEN-1:0]       dbg_data
);

    logic [XLEN-1:0] r_mem [NREGS];
    logic [AW-1:0]   w_rd_addr;
    logic [XLEN-1:0] w_dbg_word;

    // Storage array; register 0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            r_mem[wa] <= wd;
        end
    end

    // Combinational read ports.
    always_comb begin
        rd        = '0;
        w_rd_addr = '0;
        for (int p = 0; p < NREAD; p++) begin
            w_rd_addr = ra[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            rd[p*XLEN +: XLEN] = (we && (wa == w_rd_addr) && (wa != '0)) ? wd :
                                 ((w_rd_addr == '0) ? '0 : r_mem[w_rd_addr]);
`else
            rd[p*XLEN +: XLEN] = (w_rd_addr == '0) ? '0 : r_mem[w_rd_addr];
`endif
        end
    end

    // Debug captures stored contents, never the same-cycle write data.
    assign w_dbg_word = (dbg_addr == '0) ? '0 : r_mem[dbg_addr];

    // Debug response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_valid <= 1'b0;
            dbg_data  <= '0;
        end else begin
            dbg_valid <= dbg_req;
            if (dbg_req) begin
                dbg_data <= w_dbg_word;
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .we         (we),
        .wa         (wa),
        .ra         (ra),
        .rbusy      (rbusy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: default instance plus a 64-bit, 16x3 instance.
module tb_regfile_sb;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance: XLEN 32, NREGS 32, NREAD 2
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rbusy;
    logic        a_we, a_issue_en, a_dbg_req, a_dbg_valid;
    logic [4:0]  a_wa, a_issue_addr, a_dbg_addr;
    word_t       a_wd, a_dbg_data;

    // Parametrised instance: XLEN 64, NREGS 16, NREAD 3
    logic [11:0]  b_ra;
    logic [191:0] b_rd;
    logic [2:0]   b_rbusy;
    logic         b_we, b_issue_en, b_dbg_req, b_dbg_valid;
    logic [3:0]   b_wa, b_issue_addr, b_dbg_addr;
    logic [63:0]  b_wd, b_dbg_data;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_sb u_dut (
        .clk(clk), .rst(rst), .ra(a_ra), .rd(a_rd), .rbusy(a_rbusy),
        .we(a_we), .wa(a_wa), .wd(a_wd), .issue_en(a_issue_en), .issue_addr(a_issue_addr),
        .dbg_req(a_dbg_req), .dbg_addr(a_dbg_addr), .dbg_valid(a_dbg_valid), .dbg_data(a_dbg_data)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3)) u_dut64 (
        .clk(clk), .rst(rst), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy),
        .we(b_we), .wa(b_wa), .wd(b_wd), .issue_en(b_issue_en), .issue_addr(b_issue_addr),
        .dbg_req(b_dbg_req), .dbg_addr(b_dbg_addr), .dbg_valid(b_dbg_valid), .dbg_data(b_dbg_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bval(input int r);
        return {32'hF00D_0000 + 32'(r), 32'h1234_5600 + 32'(r)};
    endfunction

    initial begin
        a_ra = '0; a_we = 1'b0; a_wa = '0; a_wd = '0;
        a_issue_en = 1'b0; a_issue_addr = '0; a_dbg_req = 1'b0; a_dbg_addr = '0;
        b_ra = '0; b_we = 1'b0; b_wa = '0; b_wd = '0;
        b_issue_en = 1'b0; b_issue_addr = '0; b_dbg_req = 1'b0; b_dbg_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // Build up nonzero state, then reset asynchronously mid-operation
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF;
        a_issue_en = 1'b1; a_issue_addr = 5'd5;
        a_dbg_req = 1'b1; a_dbg_addr = 5'd0;
        tick();
        a_we = 1'b0; a_issue_en = 1'b0; a_dbg_addr = 5'd5; a_ra = {5'd5, 5'd5};
        tick();
        #1;
        check("pre_rst_rd", a_rd, {32'hDEADBEEF, 32'hDEADBEEF});
        check("pre_rst_rbusy", 64'(a_rbusy), 64'd3);
        check("pre_rst_dbg_valid", 64'(a_dbg_valid), 64'd1);
        check("pre_rst_dbg_data", 64'(a_dbg_data), 64'hDEADBEEF);
        a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h1; a_dbg_req = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_rd", a_rd, 64'd0);
        check("rst_rbusy", 64'(a_rbusy), 64'd0);
        check("rst_dbg_valid", 64'(a_dbg_valid), 64'd0);
        check("rst_dbg_data", 64'(a_dbg_data), 64'd0);
        a_we = 1'b0; a_dbg_req = 1'b0;
        tick();
        rst = 1'b0;

        // Write then read on both ports; writes to x0 discarded
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF; a_ra = {5'd3, 5'd3};
        tick();
        a_we = 1'b0; a_ra = {5'd5, 5'd5};
        #1;
        check("rd_x5_both", a_rd, {32'hDEADBEEF, 32'hDEADBEEF});
        a_we = 1'b1; a_wa = 5'd0; a_wd = 32'hFFFFFFFF;
        tick();
        a_we = 1'b0; a_ra = {5'd0, 5'd0};
        #1;
        check("rd_x0", a_rd, 64'd0);

        // Same-cycle write visibility
        a_we = 1'b1; a_wa = 5'd7; a_wd = 32'h0000AAAA;
        tick();
        a_wd = 32'h00001234; a_ra = {5'd5, 5'd7};
        #1;
        check("rd_same_cycle", 64'(a_rd[31:0]), BYP ? 64'h1234 : 64'hAAAA);
        check("rd_other_port", 64'(a_rd[63:32]), 64'hDEADBEEF);
        tick();
        a_we = 1'b0;
        #1;
        check("rd_after_write", 64'(a_rd[31:0]), 64'h1234);

        // Scoreboard set / clear
        a_issue_en = 1'b1; a_issue_addr = 5'd3; a_ra = {5'd3, 5'd3};
        #1;
        check("busy_not_yet", 64'(a_rbusy), 64'd0);
        tick();
        a_issue_en = 1'b0;
        #1;
        check("busy_set", 64'(a_rbusy), 64'd3);
        a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h33; a_ra = {5'd5, 5'd3};
        #1;
        check("busy_wb_cycle", 64'(a_rbusy), BYP ? 64'd0 : 64'd1);
        tick();
        a_we = 1'b0;
        #1;
        check("busy_cleared", 64'(a_rbusy), 64'd0);

        a_issue_en = 1'b1; a_issue_addr = 5'd3; a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h44;
        tick();
        a_issue_en = 1'b0; a_we = 1'b0;
        #1;
        check("busy_set_wins", 64'(a_rbusy), 64'd1);
        check("rd_set_wins_data", 64'(a_rd[31:0]), 64'h44);
        a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h33;
        tick();
        a_we = 1'b0;
        #1;
        check("busy_reclear", 64'(a_rbusy), 64'd0);

        a_issue_en = 1'b1; a_issue_addr = 5'd0; a_ra = {5'd0, 5'd0};
        tick();
        a_issue_en = 1'b0;
        #1;
        check("busy_x0", 64'(a_rbusy), 64'd0);

        // Debug channel: back-to-back requests
        a_we = 1'b1; a_wa = 5'd1; a_wd = 32'h11; tick();
        a_wa = 5'd2; a_wd = 32'h22; tick();
        a_wa = 5'd3; a_wd = 32'h33; tick();
        a_we = 1'b0;
        a_dbg_req = 1'b1; a_dbg_addr = 5'd1;
        tick();
        check("dbg_v1", 64'(a_dbg_valid), 64'd1);
        check("dbg_d1", 64'(a_dbg_data), 64'h11);
        a_dbg_addr = 5'd2;
        tick();
        check("dbg_v2", 64'(a_dbg_valid), 64'd1);
        check("dbg_d2", 64'(a_dbg_data), 64'h22);
        a_dbg_addr = 5'd3;
        tick();
        check("dbg_v3", 64'(a_dbg_valid), 64'd1);
        check("dbg_d3", 64'(a_dbg_data), 64'h33);
        a_dbg_req = 1'b0;
        tick();
        check("dbg_v_drop", 64'(a_dbg_valid), 64'd0);
        check("dbg_d_hold", 64'(a_dbg_data), 64'h33);

        // Debug captures pre-write contents
        a_dbg_req = 1'b1; a_dbg_addr = 5'd1; a_we = 1'b1; a_wa = 5'd1; a_wd = 32'h99;
        tick();
        a_we = 1'b0;
        check("dbg_prewrite", 64'(a_dbg_data), 64'h11);
        a_dbg_addr = 5'd2;
        tick();
        check("dbg_mid_valid", 64'(a_dbg_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("dbg_rst_valid", 64'(a_dbg_valid), 64'd0);
        check("dbg_rst_data", 64'(a_dbg_data), 64'd0);
        a_dbg_req = 1'b0;
        tick();
        rst = 1'b0;

        // 64-bit, 16-entry, 3-port instance: fill and read back everything
        for (int r = 1; r < 16; r++) begin
            b_we = 1'b1; b_wa = 4'(r); b_wd = bval(r);
            tick();
        end
        b_we = 1'b0;
        for (int r = 0; r < 16; r++) begin
            b_ra = {4'(r), 4'(r), 4'(r)};
            #1;
            for (int p = 0; p < 3; p++) begin
                check($sformatf("p64_r%0d_port%0d", r, p), b_rd[p*64 +: 64], (r == 0) ? 64'd0 : bval(r));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
